// File: rtl/avalon_cmd_master.sv
// rtl/avalon_cmd_master.sv - byte-framed command decoder driving single Avalon-MM reads/writes
module avalon_cmd_master #(
  parameter int TIMEOUT_CYCLES = 50_000,
  parameter int BUS_TIMEOUT    = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic [15:0] error_count
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BT_W = $clog2(BUS_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BT_W-1:0] BT_LAST = BT_W'(BUS_TIMEOUT - 1);

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_WDATA,
    S_BUS_WRITE,
    S_BUS_READ,
    S_RESP,
    S_NAK
  } state_t;

  state_t          state;
  logic            is_write;
  logic [15:0]     addr_q;
  logic [2:0]      byte_cnt;
  logic [23:0]     wdata_sr;
  logic [23:0]     resp_sr;
  logic [1:0]      resp_left;
  logic [TO_W-1:0] to_cnt;
  logic [BT_W-1:0] bus_cnt;
  logic            rx_fire;
  logic            tx_fire;

  assign rx_fire = rx_valid && rx_ready;
  assign tx_fire = tx_valid && tx_ready;

  // Frame decode, bus sequencing and response streaming; all outputs registered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      is_write      <= 1'b0;
      addr_q        <= 16'h0000;
      byte_cnt      <= 3'd0;
      wdata_sr      <= 24'h000000;
      resp_sr       <= 24'h000000;
      resp_left     <= 2'd0;
      to_cnt        <= '0;
      bus_cnt       <= '0;
      rx_ready      <= 1'b0;
      tx_data       <= 8'h00;
      tx_valid      <= 1'b0;
      avm_address   <= 16'h0000;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= 32'h0000_0000;
      busy          <= 1'b0;
      error_count   <= 16'h0000;
    end else begin
      case (state)
        S_IDLE: begin
          to_cnt   <= '0;
          rx_ready <= 1'b1;
          if (rx_fire) begin
            busy <= 1'b1;
            if (rx_data == OP_WRITE || rx_data == OP_READ) begin
              is_write <= (rx_data == OP_WRITE);
              state    <= S_ADDR_HI;
            end else begin
              state    <= S_NAK;
              rx_ready <= 1'b0;
              tx_valid <= 1'b1;
              tx_data  <= NAK_BYTE;
              if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
            end
          end
        end

        S_ADDR_HI, S_ADDR_LO, S_WDATA: begin
          if (rx_fire) begin
            to_cnt <= '0;
            if (state == S_ADDR_HI) begin
              addr_q[15:8] <= rx_data;
              state        <= S_ADDR_LO;
            end else if (state == S_ADDR_LO) begin
              addr_q[7:0] <= rx_data;
              if (is_write) begin
                byte_cnt <= 3'd0;
                state    <= S_WDATA;
              end else begin
                // Last byte of a read frame: strobe goes out next cycle
                avm_address <= {addr_q[15:8], rx_data};
                avm_read    <= 1'b1;
                bus_cnt     <= '0;
                rx_ready    <= 1'b0;
                state       <= S_BUS_READ;
              end
            end else begin
              wdata_sr <= {wdata_sr[15:0], rx_data};
              if (byte_cnt == 3'd3) begin
                avm_address   <= addr_q;
                avm_writedata <= {wdata_sr, rx_data};
                avm_write     <= 1'b1;
                bus_cnt       <= '0;
                rx_ready      <= 1'b0;
                state         <= S_BUS_WRITE;
              end else begin
                byte_cnt <= byte_cnt + 3'd1;
              end
            end
          end else if (to_cnt == TO_LAST) begin
            // Host went silent mid-frame: drop the partial frame and NAK
            state    <= S_NAK;
            rx_ready <= 1'b0;
            tx_valid <= 1'b1;
            tx_data  <= NAK_BYTE;
            if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        S_BUS_WRITE, S_BUS_READ: begin
          if (!avm_waitrequest) begin
            avm_write <= 1'b0;
            avm_read  <= 1'b0;
            tx_valid  <= 1'b1;
            state     <= S_RESP;
            if (state == S_BUS_WRITE) begin
              tx_data   <= ACK_BYTE;
              resp_left <= 2'd0;
            end else begin
              tx_data   <= avm_readdata[31:24];
              resp_sr   <= avm_readdata[23:0];
              resp_left <= 2'd3;
            end
          end else if (bus_cnt == BT_LAST) begin
            // Slave never released the bus: abandon the transfer
            avm_write <= 1'b0;
            avm_read  <= 1'b0;
            state     <= S_NAK;
            tx_valid  <= 1'b1;
            tx_data   <= NAK_BYTE;
            if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
          end else begin
            bus_cnt <= bus_cnt + 1'b1;
          end
        end

        S_RESP: begin
          if (tx_fire) begin
            if (resp_left == 2'd0) begin
              tx_valid <= 1'b0;
              rx_ready <= 1'b1;
              busy     <= 1'b0;
              state    <= S_IDLE;
            end else begin
              tx_data   <= resp_sr[23:16];
              resp_sr   <= {resp_sr[15:0], 8'h00};
              resp_left <= resp_left - 2'd1;
            end
          end
        end

        S_NAK: begin
          if (tx_fire) begin
            tx_valid <= 1'b0;
            rx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_cmd_master.sv
// tb/tb_avalon_cmd_master.sv - table-driven scoreboard bench for avalon_cmd_master
module tb_avalon_cmd_master;

  localparam int TO = 40;
  localparam int BT = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [15:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = 32'hBAD0_BAD0;
  logic        avm_waitrequest = 1'b1;
  logic        busy;
  logic [15:0] error_count;

  avalon_cmd_master #(.TIMEOUT_CYCLES(TO), .BUS_TIMEOUT(BT)) dut (
    .clock(clock), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .busy(busy), .error_count(error_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [55:0] frame;
    int          nbytes;
    int          stall;
    bit          stuck;
    bit          bp;
    logic [31:0] rdata;
    int          kind;     // 0 none, 1 write, 2 read
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] resp;
    int          nresp;
  } vec_t;

  vec_t vecs[8];

  int n_vec = 0;
  int n_miss = 0;
  int exp_err = 0;
  logic [7:0] exp_q[$];

  int          stall_cfg = 0;
  bit          stuck = 1'b0;
  bit          bp = 1'b0;
  logic [31:0] rdata_cfg = 32'h0;
  bit          in_strobe = 1'b0;
  bit          prev_done = 1'b0;
  bit          strobe_seen = 1'b0;
  int          held = 0;
  int          last_len = 0;
  logic [15:0] s_addr = 16'h0;
  logic [31:0] s_wdata = 32'h0;
  int          s_kind = 0;
  bit          hold_pending = 1'b0;
  logic [7:0]  hold_data = 8'h0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Slave model and response monitor, evaluated on the falling edge
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clock);
      if (reset) begin
        in_strobe = 1'b0; prev_done = 1'b0; hold_pending = 1'b0;
        avm_waitrequest = 1'b1; tx_ready = 1'b1;
      end else begin
        if (avm_read || avm_write) begin
          check("strobe_excl", 64'(avm_read && avm_write), 64'(0));
          check("no_reassert", 64'(prev_done), 64'(0));
          if (!in_strobe) begin
            in_strobe = 1'b1; held = 0; strobe_seen = 1'b1;
            s_addr = avm_address; s_wdata = avm_writedata; s_kind = avm_write ? 1 : 2;
          end else begin
            check("addr_stable", 64'(avm_address), 64'(s_addr));
            if (avm_write) check("wdata_stable", 64'(avm_writedata), 64'(s_wdata));
          end
          avm_waitrequest = stuck || (held < stall_cfg);
          avm_readdata = avm_waitrequest ? 32'hBAD0_BAD0 : rdata_cfg;
          held++;
          last_len = held;
          prev_done = !avm_waitrequest;
        end else begin
          in_strobe = 1'b0; prev_done = 1'b0;
          avm_waitrequest = 1'b1; avm_readdata = 32'hBAD0_BAD0;
        end

        tx_ready = bp ? !tx_ready : 1'b1;
        if (hold_pending) begin
          check("tx_held", 64'(tx_valid), 64'(1));
          if (tx_valid) check("tx_stable", 64'(tx_data), 64'(hold_data));
        end
        hold_pending = 1'b0;
        if (tx_valid) begin
          if (tx_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
              n_miss++;
              $display("FAIL tx_extra: got %02h, expected no byte", tx_data);
            end else begin
              e = exp_q.pop_front();
              if (tx_data !== e) begin
                n_miss++;
                $display("FAIL tx_byte: got %02h, expected %02h", tx_data, e);
              end
            end
          end else begin
            hold_pending = 1'b1;
            hold_data = tx_data;
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int k;
    @(posedge clock); #1;
    rx_data = b; rx_valid = 1'b1;
    k = 0;
    do begin @(negedge clock); k++; end while (!rx_ready && k < 500);
    if (!rx_ready) begin
      n_vec++; n_miss++;
      $display("FAIL rx_accept: got rx_ready 0, expected 1 within 500 cycles");
    end
    @(posedge clock); #1;
    rx_valid = 1'b0; rx_data = 8'h00;
  endtask

  task automatic wait_resp(input int exp_lat, input logic [1:0] exp_strobe);
    int  c;
    bit  got;
    c = 0; got = 1'b0;
    for (int k = 0; k < BT + TO + 20 && !got; k++) begin
      @(negedge clock);
      c++;
      if (c == 1) check("strobe_n1", 64'({avm_write, avm_read}), 64'(exp_strobe));
      if (tx_valid) got = 1'b1;
    end
    check("resp_lat", 64'(got ? c : -1), 64'(exp_lat));
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (exp_q.size() == 0 && !busy) break;
      @(negedge clock);
    end
    check("drain_q", 64'(exp_q.size()), 64'(0));
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_rx_ready", 64'(rx_ready), 64'(1));
  endtask

  task automatic apply_vec(input vec_t v);
    int exp_len;
    stall_cfg = v.stall; stuck = v.stuck; rdata_cfg = v.rdata; bp = v.bp;
    strobe_seen = 1'b0;
    for (int i = 0; i < v.nresp; i++) exp_q.push_back(v.resp[8*(v.nresp-1-i) +: 8]);
    if (v.nresp == 1 && v.resp[7:0] == 8'h15) exp_err++;
    for (int i = 0; i < v.nbytes; i++) send_byte(v.frame[8*(v.nbytes-1-i) +: 8]);
    exp_len = v.stuck ? BT : v.stall + 1;
    wait_resp(v.kind == 0 ? 1 : exp_len + 1,
              v.kind == 1 ? 2'b10 : (v.kind == 2 ? 2'b01 : 2'b00));
    drain();
    check("strobe_seen", 64'(strobe_seen), 64'(v.kind != 0));
    if (v.kind != 0) begin
      check("strobe_len", 64'(last_len), 64'(exp_len));
      check("bus_kind", 64'(s_kind), 64'(v.kind));
      check("bus_addr", 64'(s_addr), 64'(v.addr));
      if (v.kind == 1) check("bus_wdata", 64'(s_wdata), 64'(v.wdata));
    end
    check("error_count", 64'(error_count), 64'(exp_err));
    bp = 1'b0; stuck = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    vecs[0] = '{56'h57_0302_0000_01F4, 7, 0, 1'b0, 1'b0, 32'h0,         1, 16'h0302, 32'h0000_01F4, 32'h06,        1};
    vecs[1] = '{56'h52_0001,           3, 1, 1'b0, 1'b0, 32'h1111_1111, 2, 16'h0001, 32'h0,         32'h1111_1111, 4};
    vecs[2] = '{56'h52_0102,           3, 0, 1'b0, 1'b1, 32'hDEAD_BEEF, 2, 16'h0102, 32'h0,         32'hDEAD_BEEF, 4};
    vecs[3] = '{56'h41,                1, 0, 1'b0, 1'b0, 32'h0,         0, 16'h0,    32'h0,         32'h15,        1};
    vecs[4] = '{56'h57_AA55_1234_5678, 7, 3, 1'b0, 1'b0, 32'h0,         1, 16'hAA55, 32'h1234_5678, 32'h06,        1};
    vecs[5] = '{56'h52_0005,           3, 0, 1'b1, 1'b0, 32'h0,         2, 16'h0005, 32'h0,         32'h15,        1};
    vecs[6] = '{56'h52_FF00,           3, 0, 1'b0, 1'b0, 32'hA5C3_0F96, 2, 16'hFF00, 32'h0,         32'hA5C3_0F96, 4};
    vecs[7] = '{56'h57_0007_CAFE_F00D, 7, 2, 1'b0, 1'b1, 32'h0,         1, 16'h0007, 32'hCAFE_F00D, 32'h06,        1};

    // Reset values
    #3 reset = 1'b1;
    @(negedge clock);
    check("rst_rx_ready", 64'(rx_ready), 64'(0));
    check("rst_tx_valid", 64'(tx_valid), 64'(0));
    check("rst_tx_data", 64'(tx_data), 64'(0));
    check("rst_strobes", 64'({avm_read, avm_write}), 64'(0));
    check("rst_address", 64'(avm_address), 64'(0));
    check("rst_writedata", 64'(avm_writedata), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_error_count", 64'(error_count), 64'(0));
    @(negedge clock);
    reset = 1'b0;

    // Long silence in IDLE must not time out
    repeat (TO + 5) @(negedge clock);
    check("idle_no_tx", 64'(tx_valid), 64'(0));
    check("idle_busy0", 64'(busy), 64'(0));
    check("idle_ready", 64'(rx_ready), 64'(1));

    for (int i = 0; i < 8; i++) apply_vec(vecs[i]);

    // Partial frame followed by silence
    strobe_seen = 1'b0;
    exp_q.push_back(8'h15);
    exp_err++;
    send_byte(8'h57);
    send_byte(8'h03);
    wait_resp(TO + 1, 2'b00);
    drain();
    check("to_no_write", 64'(strobe_seen), 64'(0));
    check("to_error_count", 64'(error_count), 64'(exp_err));

    // Reset while a write strobe is stalled
    stuck = 1'b1;
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h10);
    send_byte(8'hCA); send_byte(8'hFE); send_byte(8'h00); send_byte(8'h01);
    k = 0;
    while (!avm_write && k < 10) begin @(negedge clock); k++; end
    check("midrst_write_seen", 64'(avm_write), 64'(1));
    #2 reset = 1'b1;
    #1;
    check("midrst_write", 64'(avm_write), 64'(0));
    check("midrst_tx_valid", 64'(tx_valid), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_rx_ready", 64'(rx_ready), 64'(0));
    check("midrst_address", 64'(avm_address), 64'(0));
    check("midrst_error_count", 64'(error_count), 64'(0));
    exp_err = 0;
    exp_q.delete();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    stuck = 1'b0;
    @(negedge clock);
    apply_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
